// File: rtl/counter_sequencer.sv
// Two-requester command sequencer that drives an external 4-bit up/down/load counter.
// Define SEQ_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module counter_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [3:0]  req_op,
    input  logic [11:0] req_arg,
    output logic [1:0]  req_ready,
    output logic        ctr_en,
    output logic        ctr_dir,
    output logic        ctr_load,
    output logic [5:0]  ctr_data,
    input  logic [3:0]  ctr_out,
    output logic        done,
    output logic        done_id,
    output logic        sat,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ARB, LOAD, STEP, DONE} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t     state, state_nxt;
    logic [1:0] op_q;
    logic       id_q;
    logic [5:0] remaining;
    logic [3:0] ctr_q;
    logic       sat_q, err_q, sat_nxt, err_nxt;
    logic       capture, step;
    logic       grant_any, grant_id;
    logic [1:0] sel_op;
    logic [5:0] sel_arg;

    assign grant_any = |req_valid;

`ifdef SEQ_ROUND_ROBIN_EN
    logic ptr;

    // The pointer holder wins ties; after any grant the pointer moves to the other requester.
    assign grant_id = (req_valid == 2'b11) ? ptr : req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (state == ARB && grant_any)
            ptr <= ~grant_id;
    end
`else
    assign grant_id = ~req_valid[0];
`endif

    assign sel_op  = grant_id ? req_op[3:2]   : req_op[1:0];
    assign sel_arg = grant_id ? req_arg[11:6] : req_arg[5:0];

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        ctr_en    = 1'b0;
        ctr_dir   = 1'b0;
        ctr_load  = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        step      = 1'b0;
        sat_nxt   = sat_q;
        err_nxt   = err_q;
        case (state)
            IDLE: if (grant_any) state_nxt = ARB;
            ARB: begin
                if (grant_any) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    capture   = 1'b1;
                    state_nxt = (sel_op == OP_UP || sel_op == OP_DOWN) ? STEP : LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                ctr_en    = 1'b1;
                ctr_load  = 1'b1;
                sat_nxt   = (ctr_data > 6'd12);
                err_nxt   = 1'b0;
                state_nxt = DONE;
            end
            STEP: begin
                // Decisions use the counter value sampled at this cycle's rising edge,
                // which already reflects the step issued in the previous cycle.
                if (remaining == 6'd0) begin
                    sat_nxt   = 1'b0;
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (ctr_q == 4'd15) begin
                    sat_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if ((op_q == OP_UP && ctr_q >= 4'd12) || (op_q == OP_DOWN && ctr_q == 4'd0)) begin
                    sat_nxt   = 1'b1;
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else begin
                    ctr_en  = 1'b1;
                    ctr_dir = (op_q == OP_UP);
                    step    = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done_id = done & id_q;
    assign sat     = done & sat_q;
    assign err     = done & err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_LOAD;
            id_q      <= 1'b0;
            remaining <= 6'd0;
            ctr_data  <= 6'd0;
            ctr_q     <= 4'd0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            ctr_q <= ctr_out;
            sat_q <= sat_nxt;
            err_q <= err_nxt;
            if (capture) begin
                op_q      <= sel_op;
                id_q      <= grant_id;
                remaining <= (sel_op == OP_UP || sel_op == OP_DOWN) ? sel_arg : 6'd0;
                // Load data changes only for commands that reach LOAD, so it holds otherwise.
                if (sel_op == OP_LOAD)
                    ctr_data <= sel_arg;
                else if (sel_op == OP_CLEAR)
                    ctr_data <= 6'd0;
            end else if (step) begin
                remaining <= remaining - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: a command-level model predicts every cycle's outputs.
// An external counter model reacts to the sequencer on the falling clock edge.
module tb_counter_sequencer;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [3:0]  req_op = 4'd0;
    logic [11:0] req_arg = 12'd0;
    logic [1:0]  req_ready;
    logic        ctr_en, ctr_dir, ctr_load;
    logic [5:0]  ctr_data;
    logic [3:0]  ctr_out = 4'd0;
    logic        done, done_id, sat, err, busy;

    typedef struct packed {
        logic [1:0] ready;
        logic       en;
        logic       dir;
        logic       load;
        logic [5:0] data;
        logic       done;
        logic       id;
        logic       sat;
        logic       err;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   chk_on = 1'b0;
    int   en_cnt = 0;
    int   done_cnt = 0;
    logic last_sat = 1'b0, last_err = 1'b0, last_id = 1'b0;
    logic grant_log[$];

    // Model state: what the counter and load register should hold, and the arbitration pointer.
    logic [5:0] m_data = 6'd0;
    logic [3:0] m_ctr = 4'd0;
    logic       m_ptr = 1'b0;

    counter_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_arg(req_arg),
        .req_ready(req_ready), .ctr_en(ctr_en), .ctr_dir(ctr_dir), .ctr_load(ctr_load),
        .ctr_data(ctr_data), .ctr_out(ctr_out), .done(done), .done_id(done_id),
        .sat(sat), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // External counter: loads or steps on the falling edge whenever enabled.
    always @(negedge clk) begin
        if (ctr_en) begin
            if (ctr_load)     ctr_out <= ctr_data[3:0];
            else if (ctr_dir) ctr_out <= ctr_out + 4'd1;
            else              ctr_out <= ctr_out - 4'd1;
        end
    end

    function automatic exp_t rec(input logic [1:0] rdy, input logic en, input logic dir,
                                 input logic load, input logic dn, input logic id,
                                 input logic s, input logic e, input logic bsy);
        exp_t r;
        r.ready = rdy; r.en = en; r.dir = dir; r.load = load; r.data = m_data;
        r.done = dn; r.id = id; r.sat = s; r.err = e; r.busy = bsy;
        return r;
    endfunction

    // Compare process: every cycle, the DUT outputs must equal the next predicted record,
    // or an idle record once the prediction queue is empty.
    always @(negedge clk) begin : compare
        exp_t e, a;
        cyc++;
        if (ctr_en) en_cnt++;
        if (done) begin
            done_cnt++;
            last_sat = sat; last_err = err; last_id = done_id;
            grant_log.push_back(done_id);
        end
        if (chk_on) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : rec(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            a.ready = req_ready; a.en = ctr_en; a.dir = ctr_dir; a.load = ctr_load;
            a.data = ctr_data; a.done = done; a.id = done_id; a.sat = sat; a.err = err;
            a.busy = busy;
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("[TB] FAIL cycle_outputs@%0d: got %h expected %h", cyc, a, e);
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Called just after a rising edge with the DUT idle. Predicts the whole trace of
    // ngrants commands from the command rules, then holds req_valid until the last grant.
    task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] op,
                                 input logic [11:0] arg, input int ngrants);
        int         len, last_arb, rem;
        logic       g, up, s, e, stop;
        logic [1:0] o;
        logic [5:0] a, d;
        en_cnt = 0;
        exp_q.push_back(rec(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        len = 1;
        last_arb = 1;
        for (int n = 0; n < ngrants; n++) begin
            if (n > 0) begin
                exp_q.push_back(rec(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                len++;
            end
`ifdef SEQ_ROUND_ROBIN_EN
            g = (valid == 2'b11) ? m_ptr : valid[1];
            m_ptr = ~g;
`else
            g = ~valid[0];
`endif
            exp_q.push_back(rec(g ? 2'b10 : 2'b01, 0, 0, 0, 0, 0, 0, 0, 1));
            len++;
            last_arb = len - 1;
            o = g ? op[3:2] : op[1:0];
            a = g ? arg[11:6] : arg[5:0];
            s = 1'b0;
            e = 1'b0;
            if (o == OP_LOAD || o == OP_CLEAR) begin
                d = (o == OP_CLEAR) ? 6'd0 : a;
                m_data = d;
                exp_q.push_back(rec(2'b00, 1, 0, 1, 0, 0, 0, 0, 1));
                len++;
                m_ctr = d[3:0];
                s = (d > 6'd12);
            end else begin
                up = (o == OP_UP);
                rem = int'(a);
                stop = 1'b0;
                while (!stop) begin
                    if (rem == 0) stop = 1'b1;
                    else if (m_ctr == 4'd15) begin e = 1'b1; stop = 1'b1; end
                    else if (up ? (m_ctr >= 4'd12) : (m_ctr == 4'd0)) begin s = 1'b1; stop = 1'b1; end
                    else begin
                        exp_q.push_back(rec(2'b00, 1, up, 0, 0, 0, 0, 0, 1));
                        len++;
                        m_ctr = up ? m_ctr + 4'd1 : m_ctr - 4'd1;
                        rem--;
                    end
                end
                exp_q.push_back(rec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
                len++;
            end
            exp_q.push_back(rec(2'b00, 0, 0, 0, 1, g, s, e, 1));
            len++;
        end
        req_valid = valid;
        req_op = op;
        req_arg = arg;
        for (int i = 1; i <= len; i++) begin
            @(posedge clk);
            #1;
            if (i == last_arb + 1) req_valid = 2'b00;
        end
    endtask

    initial begin
        logic [2:0] grants;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {req_ready, ctr_en, ctr_dir, ctr_load, ctr_data, done, done_id, sat, err, busy}, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        applyStimulus(2'b01, {OP_LOAD, OP_LOAD}, {6'd0, 6'd7}, 1);
        checkOutput("load7_en_cycles", en_cnt, 1);
        checkOutput("load7_ctr", ctr_out, 7);
        checkOutput("load7_sat", last_sat, 0);
        checkOutput("load7_id", last_id, 0);

        applyStimulus(2'b01, {OP_LOAD, OP_LOAD}, {6'd0, 6'd20}, 1);
        checkOutput("load20_sat", last_sat, 1);
        checkOutput("load20_ctr", ctr_out, 4);

        applyStimulus(2'b01, {OP_LOAD, OP_LOAD}, {6'd0, 6'd10}, 1);
        applyStimulus(2'b01, {OP_LOAD, OP_UP}, {6'd0, 6'd5}, 1);
        checkOutput("up_sat_en_cycles", en_cnt, 2);
        checkOutput("up_sat_ctr", ctr_out, 12);
        checkOutput("up_sat_flag", last_sat, 1);

        applyStimulus(2'b01, {OP_LOAD, OP_LOAD}, {6'd0, 6'd3}, 1);
        applyStimulus(2'b01, {OP_LOAD, OP_DOWN}, {6'd0, 6'd3}, 1);
        checkOutput("down3_en_cycles", en_cnt, 3);
        checkOutput("down3_ctr", ctr_out, 0);
        checkOutput("down3_sat", last_sat, 0);
        applyStimulus(2'b01, {OP_LOAD, OP_DOWN}, {6'd0, 6'd1}, 1);
        checkOutput("down_at0_en_cycles", en_cnt, 0);
        checkOutput("down_at0_sat", last_sat, 1);

        applyStimulus(2'b01, {OP_LOAD, OP_LOAD}, {6'd0, 6'd15}, 1);
        applyStimulus(2'b01, {OP_LOAD, OP_UP}, {6'd0, 6'd4}, 1);
        checkOutput("err_en_cycles", en_cnt, 0);
        checkOutput("err_flag", last_err, 1);
        checkOutput("err_sat", last_sat, 0);
        applyStimulus(2'b01, {OP_LOAD, OP_CLEAR}, {6'd0, 6'd9}, 1);
        checkOutput("clear_data", ctr_data, 0);
        checkOutput("clear_ctr", ctr_out, 0);

        applyStimulus(2'b10, {OP_UP, OP_LOAD}, {6'd0, 6'd0}, 1);
        checkOutput("zero_step_en_cycles", en_cnt, 0);
        checkOutput("zero_step_flags", {last_sat, last_err}, 0);
        checkOutput("zero_step_id", last_id, 1);

        grant_log.delete();
        applyStimulus(2'b11, {OP_LOAD, OP_LOAD}, {6'd9, 6'd5}, 3);
        grants = 3'b111;
        if (grant_log.size() == 3) grants = {grant_log[0], grant_log[1], grant_log[2]};
`ifdef SEQ_ROUND_ROBIN_EN
        checkOutput("arb_grant_order", grants, 3'b010);
`else
        checkOutput("arb_grant_order", grants, 3'b000);
`endif

        // A request that vanishes before arbitration must be dropped without a grant.
        done_cnt = 0;
        exp_q.push_back(rec(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        req_valid = 2'b01;
        req_op = {OP_LOAD, OP_LOAD};
        req_arg = {6'd0, 6'd1};
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("drop_no_done", done_cnt, 0);

        // Reset in the middle of a long UP command, starting from a cleared counter.
        applyStimulus(2'b10, {OP_CLEAR, OP_LOAD}, {6'd0, 6'd0}, 1);
        chk_on = 1'b0;
        done_cnt = 0;
        req_valid = 2'b01;
        req_op = {OP_LOAD, OP_UP};
        req_arg = {6'd0, 6'd10};
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("mid_step_en", ctr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {req_ready, ctr_en, ctr_dir, ctr_load, ctr_data, done, done_id, sat, err, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_data = 6'd0;
        m_ptr = 1'b0;
        m_ctr = 4'd2;
        chk_on = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("reset_no_done", done_cnt, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ctr_hold", ctr_out, 2);

        applyStimulus(2'b10, {OP_LOAD, OP_LOAD}, {6'd6, 6'd0}, 1);
        checkOutput("resume_ctr", ctr_out, 6);
        checkOutput("resume_id", last_id, 1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 The block SHALL have these ports: clk  input  1  system clock, all state updates on rising edge.
REQ-002 The block SHALL have these ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 The block SHALL have these ports: req_valid  input  2  per-requester command valid, index = requester id.
REQ-004 The block SHALL have these ports: req_op  input  4  two 2-bit opcodes, [1:0] req0, [3:2] req1; 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-005 The block SHALL have these ports: req_arg  input  12  two 6-bit arguments, [5:0] req0, [11:6] req1; load value for LOAD, step count for UP/DOWN, ignored for CLEAR.
REQ-006 The block SHALL have these ports: req_ready  output  2  one-hot accept strobe, high for exactly one cycle in the accept cycle.
REQ-007 The block SHALL have these ports: ctr_en, ctr_dir, ctr_load  output  1 each  counter control; dir 1 = up.
REQ-008 The block SHALL have these ports: ctr_data  output  6  counter load data.
REQ-009 The block SHALL have these ports: ctr_out  input  4  counter value; the counter updates on the falling clk edge.
REQ-010 The block SHALL have these ports: done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have these ports: done_id  output  1  id of the completed command, valid with done.
REQ-012 The block SHALL have these ports: sat, err  output  1 each  completion status, valid with done.
REQ-013 The block SHALL have these ports: busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL use states IDLE, ARB, LOAD, STEP and DONE.
REQ-015 IDLE: if any req_valid bit is set, the FSM SHALL go to ARB.
REQ-016 ARB: the FSM SHALL pulse req_ready for the granted requester and capture that requester's op, arg and id, all in the same cycle.
REQ-017 ARB: the FSM SHALL go to LOAD for LOAD/CLEAR and to STEP for UP/DOWN.
REQ-018 ARB: if req_valid dropped to 0 before ARB, the FSM SHALL return to IDLE with no ready pulse.
REQ-019 LOAD: the block SHALL drive ctr_en=1 and ctr_load=1 for exactly one cycle.
REQ-020 LOAD: ctr_data SHALL be arg for LOAD and 0 for CLEAR.
REQ-021 LOAD SHALL then go to DONE with sat=(arg>12) and err=0.
REQ-022 STEP: the block SHALL evaluate conditions each cycle in this priority order: remaining==0, then ctr_out==15, then saturation, then issue a step.
REQ-023 STEP, remaining==0: the FSM SHALL go to DONE with sat=0 and err=0.
REQ-024 STEP, ctr_out==15: the FSM SHALL go to DONE with err=1 and no step issued.
REQ-025 STEP, saturation (UP with ctr_out>=12, or DOWN with ctr_out==0): the FSM SHALL go to DONE with sat=1 and no step issued.
REQ-026 STEP, otherwise: the block SHALL drive ctr_en=1, ctr_load=0 and ctr_dir per op, and decrement remaining by 1.
REQ-027 STEP: steps SHALL be issued one per cycle; a step issued in cycle N SHALL be visible on ctr_out at the start of cycle N+1.
REQ-028 A step count of 0 SHALL complete with zero ctr_en cycles.
REQ-029 DONE: the block SHALL pulse done for one cycle with done_id/sat/err, then go to IDLE.
REQ-030 Back-to-back: a new request present in IDLE SHALL be granted in the following cycle, giving at least one IDLE cycle between commands.
REQ-031 ctr_en SHALL be 0 outside LOAD and STEP, and ctr_load SHALL be 0 outside LOAD.
REQ-032 ctr_data SHALL hold its last value outside LOAD.
REQ-033 The remaining counter SHALL be 6 bits wide and SHALL never wrap below 0.
REQ-034 Requests arriving while busy SHALL be held off, with no ready pulse until the next ARB.

Reset
REQ-035 When rst_n is low, the block SHALL asynchronously force: state IDLE, req_ready=0, ctr_en=0, ctr_dir=0, ctr_load=0, ctr_data=0, done=0, done_id=0, sat=0, err=0, busy=0, remaining=0, priority pointer = requester 0.
REQ-036 Reset mid-command SHALL abandon the command with no done pulse.
REQ-037 Operation SHALL resume on the first rising edge after rst_n goes high.

Configuration
REQ-038 With macro SEQ_ROUND_ROBIN_EN defined, ARB SHALL grant round-robin: the pointer moves to the other requester after each grant, and the pointer holder wins ties.
REQ-039 Without SEQ_ROUND_ROBIN_EN, requester 0 SHALL always win ties (fixed priority) and the pointer logic SHALL be absent.

Verification
REQ-040 Reset check: rst_n low mid-STEP -> all outputs 0 immediately, no done pulse, and busy=0 after release.
REQ-041 LOAD check: req0 LOAD arg=7 -> one cycle of ctr_en=ctr_load=1 with ctr_data=7, then done with id=0, sat=0, err=0; a LOAD with arg=20 -> done with sat=1.
REQ-042 UP saturation check: ctr_out=10, UP arg=5 -> exactly 2 ctr_en cycles (ctr_out 11, 12), then done with sat=1.
REQ-043 DOWN check: ctr_out=3, DOWN arg=3 -> 3 steps to 0, then done with sat=0; a following DOWN arg=1 -> 0 steps, then done with sat=1.
REQ-044 Error check: ctr_out=15, UP arg=4 -> no ctr_en, done with err=1; a following CLEAR -> ctr_data=0 and ctr_out=0.
REQ-045 Arbitration check: both requesters valid continuously -> with SEQ_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it grants are 0,0,0.
